// File: rtl/push_button_pkg.sv
// Shared types and defaults for the push-button scheduler.
package push_button_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    REQ_PRESS     = 3'd1,
    PRESS_DELAY   = 3'd2,
    PENDING       = 3'd3,
    WAIT_RELEASE  = 3'd4,
    REQ_RELEASE   = 3'd5,
    RELEASE_DELAY = 3'd6
  } button_state_t;

  // ~20 ms at 50 MHz
  localparam int unsigned DEBOUNCE_DEFAULT      = 32'h000F_FFFF;
  localparam int unsigned NUM_BUTTONS_DEFAULT   = 4;
  localparam int unsigned COUNTER_WIDTH_DEFAULT = 32;

  // A button wants the shared timer in either request state.
  function automatic logic is_timer_request(button_state_t s);
    return (s == REQ_PRESS) || (s == REQ_RELEASE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the slot after the last grantee.
// The pointer only moves when the caller strobes advance with a live grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // First requester at or after the pointer, wrapping modulo N
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (sum >= N_WIDE) begin
        sum = sum - N_WIDE;
      end
      cand = sum[IDX_W-1:0];
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Pointer moves past the grantee once the grant is actually taken
  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_valid) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/push_button_scheduler.sv
// Push-button scheduler: one shared debounce timer for all buttons and a
// single registered event port with accept handshake.
//
// Per-button FSM states:
//   state         | meaning
//   IDLE          | released, waiting for a press level
//   REQ_PRESS     | press seen, waiting for the shared timer
//   PRESS_DELAY   | timer owned, press level sampled at expiry
//   PENDING       | debounced press, waiting for the consumer to accept
//   WAIT_RELEASE  | accepted, waiting for the pin to be released
//   REQ_RELEASE   | release seen, waiting for the shared timer
//   RELEASE_DELAY | timer owned, release level sampled at expiry
module push_button_scheduler
  import push_button_pkg::*;
#(
  parameter int          NUM_BUTTONS    = NUM_BUTTONS_DEFAULT,
  parameter int unsigned DEBOUNCE_DELAY = DEBOUNCE_DEFAULT,
  parameter int          COUNTER_WIDTH  = COUNTER_WIDTH_DEFAULT
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_BUTTONS-1:0]         raw_buttons_n,
  output logic                           event_valid,
  output logic [$clog2(NUM_BUTTONS)-1:0] event_id,
  input  logic                           event_accepted,
  output logic [NUM_BUTTONS-1:0]         pending,
  output logic                           timer_busy
);

  localparam int IDX_W = $clog2(NUM_BUTTONS);
  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_DELAY - 1);

  // ---------------------------------------------------------------- sync
  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] btn;

  // Two-stage shift toward the FSMs
  always_comb begin
    sync1_d = raw_buttons_n;
    sync2_d = sync1_q;
  end

  // Synchroniser flops come out of reset as "released" so no phantom press
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn = ~sync2_q;

  // ---------------------------------------------------------------- timer
  logic [NUM_BUTTONS-1:0]   timer_req;
  logic [NUM_BUTTONS-1:0]   timer_grant;
  logic [IDX_W-1:0]         timer_grant_idx;
  logic                     timer_grant_valid;
  logic                     timer_take;
  logic                     timer_expire;
  logic                     timer_busy_q, timer_busy_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [IDX_W-1:0]         owner_q, owner_d;

  assign timer_take   = ~timer_busy_q & timer_grant_valid;
  assign timer_expire = timer_busy_q & (count_q == LAST_COUNT);

  rr_arbiter #(.N(NUM_BUTTONS)) u_timer_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (timer_req),
    .advance     (timer_take),
    .grant       (timer_grant),
    .grant_idx   (timer_grant_idx),
    .grant_valid (timer_grant_valid)
  );

  // Counter runs only while owned and parks at the last count, so it never wraps
  always_comb begin
    timer_busy_d = timer_busy_q;
    count_d      = count_q;
    owner_d      = owner_q;
    if (timer_busy_q) begin
      if (count_q == LAST_COUNT) begin
        timer_busy_d = 1'b0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (timer_grant_valid) begin
      timer_busy_d = 1'b1;
      count_d      = '0;
      owner_d      = timer_grant_idx;
    end
  end

  // Timer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_busy_q <= 1'b0;
      count_q      <= '0;
      owner_q      <= '0;
    end else begin
      timer_busy_q <= timer_busy_d;
      count_q      <= count_d;
      owner_q      <= owner_d;
    end
  end

  assign timer_busy = timer_busy_q;

  // ---------------------------------------------------------------- event port
  logic                   event_valid_q, event_valid_d;
  logic [IDX_W-1:0]       event_id_q, event_id_d;
  logic [NUM_BUTTONS-1:0] event_sel_q, event_sel_d;
  logic [NUM_BUTTONS-1:0] evt_grant;
  logic [IDX_W-1:0]       evt_grant_idx;
  logic                   evt_grant_valid;
  logic                   evt_take;

  assign evt_take = ~event_valid_q & evt_grant_valid;

  rr_arbiter #(.N(NUM_BUTTONS)) u_event_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (pending),
    .advance     (evt_take),
    .grant       (evt_grant),
    .grant_idx   (evt_grant_idx),
    .grant_valid (evt_grant_valid)
  );

  // Offer is frozen until taken; after a transfer the port idles one cycle
  // before choosing again, which also lets the accepted button leave PENDING.
  always_comb begin
    event_valid_d = event_valid_q;
    event_id_d    = event_id_q;
    event_sel_d   = event_sel_q;
    if (event_valid_q) begin
      if (event_accepted) begin
        event_valid_d = 1'b0;
        event_sel_d   = '0;
      end
    end else if (evt_grant_valid) begin
      event_valid_d = 1'b1;
      event_id_d    = evt_grant_idx;
      event_sel_d   = evt_grant;
    end
  end

  // Event registers
  always_ff @(posedge clock) begin
    if (reset) begin
      event_valid_q <= 1'b0;
      event_id_q    <= '0;
      event_sel_q   <= '0;
    end else begin
      event_valid_q <= event_valid_d;
      event_id_q    <= event_id_d;
      event_sel_q   <= event_sel_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_id    = event_id_q;

  // ---------------------------------------------------------------- buttons
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
    button_state_t state_q, state_d;
    logic          gnt;
    logic          expire;
    logic          accept;
    logic          req_i;
    logic          pend_i;

    assign gnt    = timer_take & timer_grant[i];
    assign expire = timer_expire & (owner_q == IDX_W'(i));
    assign accept = event_valid_q & event_accepted & event_sel_q[i];

    // State register
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Next state; only the level at expiry matters, glitches in between are ignored
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:          if (btn[i])  state_d = REQ_PRESS;
        REQ_PRESS:     if (gnt)     state_d = PRESS_DELAY;
        PRESS_DELAY:   if (expire)  state_d = btn[i] ? PENDING : IDLE;
        PENDING:       if (accept)  state_d = WAIT_RELEASE;
        WAIT_RELEASE:  if (!btn[i]) state_d = REQ_RELEASE;
        REQ_RELEASE:   if (gnt)     state_d = RELEASE_DELAY;
        RELEASE_DELAY: if (expire)  state_d = btn[i] ? WAIT_RELEASE : IDLE;
        default:                    state_d = IDLE;
      endcase
    end

    // Outputs toward the timer arbiter and the event port
    always_comb begin
      req_i  = is_timer_request(state_q);
      pend_i = (state_q == PENDING);
    end

    assign timer_req[i] = req_i;
    assign pending[i]   = pend_i;
  end

endmodule

// File: tb/tb_push_button_scheduler.sv
// Bench for push_button_scheduler: directed scenarios plus random pin activity,
// checked every cycle against a behavioural model of the button protocol.
module tb_push_button_scheduler;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int IW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  raw_buttons_n;
  logic          event_valid;
  logic [IW-1:0] event_id;
  logic          event_accepted;
  logic [N-1:0]  pending;
  logic          timer_busy;

  int n_checks = 0;
  int n_fail   = 0;

  push_button_scheduler #(
    .NUM_BUTTONS    (N),
    .DEBOUNCE_DELAY (D),
    .COUNTER_WIDTH  (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .raw_buttons_n  (raw_buttons_n),
    .event_valid    (event_valid),
    .event_id       (event_id),
    .event_accepted (event_accepted),
    .pending        (pending),
    .timer_busy     (timer_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // Button phases of the press/accept/release protocol.
  localparam int P_QUIET      = 0;
  localparam int P_WANT_PRESS = 1;
  localparam int P_TIME_PRESS = 2;
  localparam int P_WAITING    = 3;
  localparam int P_HELD       = 4;
  localparam int P_WANT_REL   = 5;
  localparam int P_TIME_REL   = 6;

  int ph [N];
  bit s1 [N];
  bit s2 [N];
  bit m_busy  = 1'b0;
  int m_left  = 0;
  int m_tptr  = 0;
  bit m_valid = 1'b0;
  int m_id    = 0;
  int m_eptr  = 0;

  int g, e, idx;
  bit expd, xfer;
  bit btn_old  [N];
  bit pend_old [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      ph[i] = P_QUIET; s1[i] = 1'b0; s2[i] = 1'b0;
    end
  end

  function automatic logic [N-1:0] model_pending();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (ph[i] == P_WAITING);
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        ph[i] = P_QUIET; s1[i] = 1'b0; s2[i] = 1'b0;
      end
      m_busy = 1'b0; m_left = 0; m_tptr = 0;
      m_valid = 1'b0; m_id = 0; m_eptr = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        btn_old[i]  = s2[i];
        pend_old[i] = (ph[i] == P_WAITING);
      end
      expd = m_busy && (m_left == 1);
      xfer = m_valid && event_accepted;
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_tptr + k) % N;
          if (g < 0 && (ph[idx] == P_WANT_PRESS || ph[idx] == P_WANT_REL)) g = idx;
        end
      end
      for (int i = 0; i < N; i++) begin
        case (ph[i])
          P_QUIET:      if (btn_old[i]) ph[i] = P_WANT_PRESS;
          P_WANT_PRESS: if (g == i) ph[i] = P_TIME_PRESS;
          P_TIME_PRESS: if (expd) ph[i] = btn_old[i] ? P_WAITING : P_QUIET;
          P_WAITING:    if (xfer && m_id == i) ph[i] = P_HELD;
          P_HELD:       if (!btn_old[i]) ph[i] = P_WANT_REL;
          P_WANT_REL:   if (g == i) ph[i] = P_TIME_REL;
          P_TIME_REL:   if (expd) ph[i] = btn_old[i] ? P_HELD : P_QUIET;
          default:      ph[i] = P_QUIET;
        endcase
      end
      // timer: D owned clocks counted down
      if (g >= 0) begin
        m_busy = 1'b1; m_left = D; m_tptr = (g + 1) % N;
      end else if (m_busy) begin
        if (m_left == 1) m_busy = 1'b0;
        else m_left = m_left - 1;
      end
      // event port
      if (xfer) begin
        m_valid = 1'b0;
      end else if (!m_valid) begin
        e = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_eptr + k) % N;
          if (e < 0 && pend_old[idx]) e = idx;
        end
        if (e >= 0) begin
          m_valid = 1'b1; m_id = e; m_eptr = (e + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        s2[i] = s1[i];
        s1[i] = ~raw_buttons_n[i];
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always begin
    @(posedge clock);
    #1;
    check("event_valid", event_valid, m_valid);
    if (m_valid) check("event_id", event_id, m_id);
    check("pending", pending, model_pending());
    check("timer_busy", timer_busy, m_busy);
  end

  // ------------------------------------------------------------ stimulus
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw_buttons_n = '1;
    event_accepted = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      step(1);
      if (event_valid) seen = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit seen;
  int cnt;
  int ids[$];

  initial begin
    reset = 1'b1;
    raw_buttons_n = '1;
    event_accepted = 1'b0;
    step(3);
    check("reset_valid", event_valid, 0);
    check("reset_id", event_id, 0);
    check("reset_pending", pending, 0);
    check("reset_busy", timer_busy, 0);
    reset = 1'b0;

    // 1: single press, held offer, accept
    raw_buttons_n[0] = 1'b0;
    step(12);
    check("t1_valid_edge12", event_valid, 0);
    step(1);
    check("t1_valid_edge13", event_valid, 1);
    check("t1_id_edge13", event_id, 0);
    step(20);
    check("t1_valid_held", event_valid, 1);
    check("t1_id_held", event_id, 0);
    event_accepted = 1'b1;
    step(1);
    event_accepted = 1'b0;
    check("t1_valid_after_accept", event_valid, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (event_valid) cnt++;
    end
    check("t1_no_repeat", cnt, 0);
    raw_buttons_n[0] = 1'b1;
    step(16);

    // 2: bounce shorter than debounce
    raw_buttons_n[1] = 1'b0;
    step(3);
    raw_buttons_n[1] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (timer_busy) cnt++;
    end
    check("t2_busy_clocks", cnt, D);
    check("t2_pending", pending, 0);
    check("t2_valid", event_valid, 0);

    // 3: all buttons at once, consumer always ready
    do_reset();
    event_accepted = 1'b1;
    raw_buttons_n = '0;
    ids.delete();
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (event_valid) ids.push_back(int'(event_id));
    end
    check("t3_event_count", ids.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t3_event_order", (k < ids.size()) ? ids[k] : 99, k);
    end
    raw_buttons_n = '1;
    event_accepted = 1'b0;
    step(60);

    // 4: release must be stable for the full debounce
    event_accepted = 1'b1;
    raw_buttons_n[2] = 1'b0;
    wait_valid(30, seen);
    check("t4_first_seen", seen, 1);
    check("t4_first_id", event_id, 2);
    step(3);
    raw_buttons_n[2] = 1'b1;
    step(4);
    raw_buttons_n[2] = 1'b0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      if (event_valid) cnt++;
    end
    check("t4_no_event_short_release", cnt, 0);
    raw_buttons_n[2] = 1'b1;
    step(20);
    raw_buttons_n[2] = 1'b0;
    wait_valid(30, seen);
    check("t4_second_seen", seen, 1);
    check("t4_second_id", event_id, 2);
    raw_buttons_n[2] = 1'b1;
    event_accepted = 1'b0;
    step(20);

    // 5: two pending buttons, one released while pending
    do_reset();
    raw_buttons_n[1] = 1'b0;
    raw_buttons_n[3] = 1'b0;
    step(25);
    check("t5_offer1_valid", event_valid, 1);
    check("t5_offer1_id", event_id, 1);
    check("t5_pending_both", pending, 4'b1010);
    raw_buttons_n[3] = 1'b1;
    step(5);
    check("t5_released_still_pending", pending, 4'b1010);
    event_accepted = 1'b1;
    step(1);
    event_accepted = 1'b0;
    check("t5_gap", event_valid, 0);
    step(1);
    check("t5_offer2_valid", event_valid, 1);
    check("t5_offer2_id", event_id, 3);
    step(3);
    event_accepted = 1'b1;
    step(1);
    event_accepted = 1'b0;
    check("t5_done_valid", event_valid, 0);
    check("t5_done_pending", pending, 0);
    raw_buttons_n = '1;
    step(20);

    // 6: reset mid-delay and mid-offer
    raw_buttons_n[0] = 1'b0;
    step(6);
    check("t6_busy_in_delay", timer_busy, 1);
    reset = 1'b1;
    raw_buttons_n = '1;
    step(1);
    check("t6a_valid", event_valid, 0);
    check("t6a_pending", pending, 0);
    check("t6a_busy", timer_busy, 0);
    reset = 1'b0;
    step(20);
    check("t6a_no_event", event_valid, 0);
    raw_buttons_n[2] = 1'b0;
    wait_valid(30, seen);
    check("t6b_seen", seen, 1);
    reset = 1'b1;
    raw_buttons_n = '1;
    step(1);
    check("t6b_valid", event_valid, 0);
    check("t6b_id", event_id, 0);
    check("t6b_pending", pending, 0);
    check("t6b_busy", timer_busy, 0);
    reset = 1'b0;
    raw_buttons_n[1] = 1'b0;
    raw_buttons_n[3] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step(1);
      if (pending != 0) seen = 1'b1;
    end
    check("t6c_first_pending", pending, 4'b0010);
    raw_buttons_n = '1;
    event_accepted = 1'b1;
    step(40);
    event_accepted = 1'b0;

    // random pin activity, random consumer, rare resets
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) raw_buttons_n[b] = ~raw_buttons_n[b];
      end
      event_accepted = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 999) == 0);
      step(1);
    end
    reset = 1'b0;
    raw_buttons_n = '1;
    event_accepted = 1'b1;
    step(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
